// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter and sequencer for a shared 8:1 single-bit mux channel.
// Latency: grant 1 cycle after request; q/q_valid 1 cycle after the beat.
// Backpressure: the owner is released when en or its req drops, or when its burst is spent.
//
// Ports:
//    clk, rst_n     - rising-edge clock, asynchronous active-low reset
//    en             - arbiter enable; low blocks new grants and ends the active one
//    req[7:0]       - level-sensitive per-requester requests
//    data_in[7:0]   - mux data inputs, bit i belongs to requester i
//    sel[2:0]       - registered mux select (current or last owner)
//    gnt[7:0]       - registered one-hot grant, zero when no grant is active
//    q, q_valid     - registered selected data bit and its one-cycle beat flag
//    busy           - high while a grant or the post-release gap is in progress
module mux8_rr_arbiter #(
   parameter int MAX_BURST = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic [7:0] req,
   input  logic [7:0] data_in,
   output logic [2:0] sel,
   output logic [7:0] gnt,
   output logic       q,
   output logic       q_valid,
   output logic       busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      GAP   = 2'd2
   } state_t;

   localparam logic [3:0] LAST_BEAT = 4'(MAX_BURST - 1);

   state_t     state;
   state_t     state_nxt;
   logic [2:0] ptr;
   logic [2:0] ptr_nxt;
   logic [3:0] beat_cnt;
   logic [3:0] beat_cnt_nxt;
   logic [2:0] sel_nxt;
   logic [7:0] gnt_nxt;
   logic       q_nxt;
   logic       q_valid_nxt;

   logic [2:0] winner;
   logic       winner_vld;
   logic       beat;
   logic       release_gnt;

   // Circular priority search starting at ptr. Scanning from the farthest
   // offset down to offset 0 lets the nearest set request win.
   always_comb begin
      logic [2:0] idx;
      winner     = '0;
      winner_vld = 1'b0;
      idx        = '0;
      for (int i = 7; i >= 0; i--) begin
         idx = ptr + 3'(i);
         if (req[idx]) begin
            winner     = idx;
            winner_vld = 1'b1;
         end
      end
   end

   // A beat needs the owner still requesting with the arbiter enabled. Any
   // non-beat cycle in GRANT is a release, so simultaneous burst-limit with
   // req/en drop releases without recording a beat.
   assign beat        = (state == GRANT) && en && req[sel];
   assign release_gnt = (state == GRANT) && (!beat || (beat_cnt == LAST_BEAT));

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (en && winner_vld) state_nxt = GRANT;
         GRANT:   if (release_gnt)      state_nxt = GAP;
         GAP:                           state_nxt = IDLE;
         default:                       state_nxt = IDLE;
      endcase
   end

   // Output logic: next values of the registered outputs and bookkeeping
   always_comb begin
      sel_nxt      = sel;
      gnt_nxt      = gnt;
      q_nxt        = q;
      q_valid_nxt  = 1'b0;
      ptr_nxt      = ptr;
      beat_cnt_nxt = beat_cnt;
      case (state)
         IDLE: begin
            gnt_nxt = '0;
            if (en && winner_vld) begin
               sel_nxt      = winner;
               gnt_nxt      = 8'b1 << winner;
               beat_cnt_nxt = '0;
            end
         end
         GRANT: begin
            if (beat) begin
               q_nxt        = data_in[sel];
               q_valid_nxt  = 1'b1;
               beat_cnt_nxt = beat_cnt + 4'd1;
            end
            if (release_gnt) begin
               gnt_nxt = '0;
               // Releasing requester becomes lowest priority
               ptr_nxt = sel + 3'd1;
            end
         end
         default: begin
            gnt_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel      <= '0;
         gnt      <= '0;
         q        <= 1'b0;
         q_valid  <= 1'b0;
         ptr      <= '0;
         beat_cnt <= '0;
      end else begin
         sel      <= sel_nxt;
         gnt      <= gnt_nxt;
         q        <= q_nxt;
         q_valid  <= q_valid_nxt;
         ptr      <= ptr_nxt;
         beat_cnt <= beat_cnt_nxt;
      end
   end

   assign busy = (state == GRANT) || (state == GAP);

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Self-checking bench for mux8_rr_arbiter: directed scenarios with literal
// expectations plus a long randomized run, all checked every cycle against
// an owner/gap/beat-count model of the arbitration rules.
module tb_mux8_rr_arbiter;

   localparam int MB = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0;
   logic [7:0] req = 8'h00;
   logic [7:0] data_in = 8'h00;
   logic [2:0] sel;
   logic [7:0] gnt;
   logic       q;
   logic       q_valid;
   logic       busy;

   int vectors = 0;
   int miscompares = 0;

   // Behavioural model: who owns the channel (-1 = nobody), beats done in
   // the current grant, whether the one-cycle gap is running, and the
   // requester that currently has highest priority.
   int         m_owner = -1;
   int         m_beats = 0;
   int         m_first = 0;
   bit         m_gap = 1'b0;
   logic [2:0] m_sel = 3'd0;
   logic       m_q = 1'b0;
   logic       m_qv = 1'b0;

   mux8_rr_arbiter #(.MAX_BURST(MB)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en),
      .req     (req),
      .data_in (data_in),
      .sel     (sel),
      .gnt     (gnt),
      .q       (q),
      .q_valid (q_valid),
      .busy    (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_owner = -1;
      m_beats = 0;
      m_first = 0;
      m_gap   = 1'b0;
      m_sel   = 3'd0;
      m_q     = 1'b0;
      m_qv    = 1'b0;
   endtask

   task automatic model_edge();
      bit beat;
      int j;
      if (m_owner >= 0) begin
         beat = en && req[m_owner];
         m_qv = beat;
         if (beat) begin
            m_q = data_in[m_owner];
            m_beats++;
         end
         if (!beat || m_beats == MB) begin
            m_first = (m_owner + 1) % 8;
            m_owner = -1;
            m_gap   = 1'b1;
         end
      end else if (m_gap) begin
         m_gap = 1'b0;
         m_qv  = 1'b0;
      end else begin
         m_qv = 1'b0;
         if (en && req != 8'h00) begin
            for (int k = 0; k < 8; k++) begin
               j = (m_first + k) % 8;
               if (req[j] && m_owner < 0) m_owner = j;
            end
            m_sel   = 3'(m_owner);
            m_beats = 0;
         end
      end
   endtask

   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) model_reset();
         else        model_edge();
      end
   end

   // Per-cycle comparison against the model, away from the active edge
   initial begin
      forever begin
         @(negedge clk);
         check("sel",     {29'd0, sel}, {29'd0, m_sel});
         check("gnt",     {24'd0, gnt}, (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
         check("q",       {31'd0, q}, {31'd0, m_q});
         check("q_valid", {31'd0, q_valid}, {31'd0, m_qv});
         check("busy",    {31'd0, busy}, {31'd0, (m_owner >= 0) || m_gap});
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_gnt(input logic [7:0] g, input int bound);
      int n;
      n = 0;
      while (gnt !== g && n < bound) begin
         step();
         n++;
      end
      check("wait_gnt", {24'd0, gnt}, {24'd0, g});
   endtask

   // Steps through the current grant, counting beats, until gnt drops
   task automatic count_burst(output int beats);
      beats = 0;
      for (int n = 0; n < 40; n++) begin
         step();
         if (q_valid) beats++;
         if (gnt == 8'h00) break;
      end
   endtask

   initial begin
      int b;

      // Reset state
      #13;
      check("rst_sel",  {29'd0, sel}, 32'd0);
      check("rst_gnt",  {24'd0, gnt}, 32'd0);
      check("rst_q",    {31'd0, q}, 32'd0);
      check("rst_qv",   {31'd0, q_valid}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      rst_n = 1'b1;
      step();

      // Single requester with a 1,0,1 data stream
      en = 1'b1; req = 8'h04; data_in = 8'h00;
      step();
      check("single_gnt", {24'd0, gnt}, 32'h04);
      check("single_sel", {29'd0, sel}, 32'd2);
      data_in = 8'h04; step();
      check("single_qv0", {31'd0, q_valid}, 32'd1);
      check("single_q0",  {31'd0, q}, 32'd1);
      data_in = 8'h00; step();
      check("single_q1",  {31'd0, q}, 32'd0);
      data_in = 8'h04; step();
      check("single_q2",  {31'd0, q}, 32'd1);
      req = 8'h00; step();
      check("single_rel_gnt",  {24'd0, gnt}, 32'd0);
      check("single_rel_qv",   {31'd0, q_valid}, 32'd0);
      check("single_gap_busy", {31'd0, busy}, 32'd1);
      step();
      check("single_idle_busy", {31'd0, busy}, 32'd0);

      // Wrap-around: 7 releases, then 0 wins over 7
      req = 8'h81;
      wait_gnt(8'h80, 4);
      count_burst(b);
      check("burst7_beats", b, MB);
      step();
      check("wrap_gap2", {24'd0, gnt}, 32'd0);
      step();
      check("wrap_gnt", {24'd0, gnt}, 32'h01);
      check("wrap_sel", {29'd0, sel}, 32'd0);

      // Burst limit alternating between 2 and 5
      req = 8'h24;
      wait_gnt(8'h04, 6);
      count_burst(b);
      check("burst2_beats", b, MB);
      step();
      check("burst_gap", {24'd0, gnt}, 32'd0);
      step();
      check("burst_gnt5", {24'd0, gnt}, 32'h20);
      count_burst(b);
      check("burst5_beats", b, MB);
      step(); step();
      check("burst_gnt2", {24'd0, gnt}, 32'h04);
      req = 8'h00;
      repeat (4) step();

      // Enable control
      en = 1'b0; req = 8'h10;
      repeat (3) begin
         step();
         check("en_off_gnt", {24'd0, gnt}, 32'd0);
      end
      en = 1'b1; step();
      check("en_on_gnt", {24'd0, gnt}, 32'h10);
      check("en_on_sel", {29'd0, sel}, 32'd4);
      step();
      check("en_beat", {31'd0, q_valid}, 32'd1);
      en = 1'b0; step();
      check("en_drop_gnt",  {24'd0, gnt}, 32'd0);
      check("en_drop_qv",   {31'd0, q_valid}, 32'd0);
      check("en_drop_busy", {31'd0, busy}, 32'd1);
      step();
      check("en_idle_busy", {31'd0, busy}, 32'd0);

      // Asynchronous reset in the middle of a grant to 3
      en = 1'b1; req = 8'h08;
      wait_gnt(8'h08, 4);
      step();
      #1 rst_n = 1'b0;
      #1;
      check("arst_sel",  {29'd0, sel}, 32'd0);
      check("arst_gnt",  {24'd0, gnt}, 32'd0);
      check("arst_q",    {31'd0, q}, 32'd0);
      check("arst_qv",   {31'd0, q_valid}, 32'd0);
      check("arst_busy", {31'd0, busy}, 32'd0);
      req = 8'h09;
      #2 rst_n = 1'b1;
      step();
      check("arst_regnt", {24'd0, gnt}, 32'h01);
      check("arst_resel", {29'd0, sel}, 32'd0);

      // Full contention: grants rotate 1..7,0 after the current owner 0
      req = 8'hFF;
      for (int i = 1; i <= 8; i++) begin
         data_in = 8'($urandom);
         count_burst(b);
         check("full_beats", b, MB);
         step(); step();
         check("full_sel", {29'd0, sel}, 32'(i % 8));
      end

      // Randomized traffic
      req = 8'h00;
      repeat (3) step();
      for (int n = 0; n < 3000; n++) begin
         en = ($urandom_range(0, 15) != 0);
         if ($urandom_range(0, 3) == 0) begin
            case ($urandom_range(0, 2))
               0:       req = 8'($urandom);
               1:       req = 8'($urandom) & 8'($urandom);
               default: req = 8'h01 << $urandom_range(0, 7);
            endcase
         end
         data_in = 8'($urandom);
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mux8_rr_arbiter.md
Name: mux8_rr_arbiter

Overview:
Round-robin arbiter and sequencer that shares the 8:1 single-bit mux channel among 8 requesters. It arbitrates requests and drives the 3-bit select. It also samples the selected data bit into a registered output with a valid flag. Bursts are bounded so that no requester can hold the channel indefinitely. It sits directly in front of the muxer8 datapath and replaces static select control.

Parameters:
MAX_BURST, 4, maximum consecutive beats per grant; legal range 1..16; beat counter is 4 bits.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
en  input  1  arbiter enable; low blocks new grants and ends any active grant
req  input  8  per-requester request, level-sensitive; bit i = requester i
data_in  input  8  mux data inputs; bit i belongs to requester i
sel  output  3  mux select, registered; index of current or last granted requester
gnt  output  8  one-hot grant, registered; all-zero when no grant is active
q  output  1  registered selected data bit
q_valid  output  1  high for one cycle per transferred beat
busy  output  1  high in GRANT or GAP state

Behaviour:
- One clock domain. Reset is asynchronous and active-low; all state clears immediately on rst_n low.
- Reset values:
  - sel=0, gnt=0, q=0, q_valid=0, busy=0.
  - Priority pointer ptr=0, beat_cnt=0, state=IDLE.
- States: IDLE, GRANT, GAP.
- IDLE:
  - If en=1 and req!=0: choose the first set req bit searching circularly from ptr upward (wrap 7->0).
  - At the next edge: gnt=onehot(winner), sel=winner, beat_cnt=0, state=GRANT.
  - Request-to-grant latency is 1 cycle.
  - Otherwise stay in IDLE; sel holds its last value and gnt=0.
- GRANT:
  - A beat is a cycle with en=1 and req[sel]=1.
  - On a beat edge: q<=data_in[sel], q_valid<=1, beat_cnt++. q therefore lags data_in by 1 cycle.
  - On a non-beat edge: q_valid<=0 and q holds.
  - Release conditions, evaluated at the edge:
    - en=0, or
    - req[sel]=0, or
    - a beat occurs with beat_cnt==MAX_BURST-1.
  - On release: gnt<=0, ptr<=(sel+1) mod 8 (7 wraps to 0), state<=GAP.
  - The final beat's q/q_valid still registers when the release is caused by the burst limit.
- GAP:
  - Lasts exactly 1 cycle; gnt=0, q_valid<=0; then state goes to IDLE.
  - Guarantees at least 1 idle cycle on the channel between owners.
  - The earliest next grant is 2 edges after release.
- Fairness:
  - ptr advances only on release, so the releasing requester becomes lowest priority.
  - With all 8 requesting continuously, grants go 0,1,...,7,0,...
- Requests from other bits are ignored while a grant is active.
- Simultaneous events:
  - A req drop and the burst-limit edge in the same cycle count as a req-drop release; no beat is recorded.
  - The burst limit and en=0 in the same cycle count as an en release; no beat is recorded.
- MAX_BURST=1: each grant yields exactly 1 beat, then GAP.
- sel never changes while gnt!=0. sel changes only on the IDLE->GRANT edge.
- Reset asserted mid-burst: outputs return to their reset values asynchronously. After release the block restarts in IDLE with ptr=0.

Test Plan:
- Single requester, data bit stream: rst_n 0->1; en=1; req=8'h04 for 3 cycles, then 0; data_in[2] toggles 1,0,1.
  -> gnt=8'h04 and sel=2 one edge after req; q_valid high 3 cycles with q=1,0,1; then GAP; busy low 2 edges after the req drop.
- Burst limit: MAX_BURST=4; req=8'h24 held.
  -> Grant order 2 (4 beats), gap, 5 (4 beats), gap, 2, ...
  -> Exactly 4 q_valid pulses per grant; gnt=0 for 2 cycles between owners.
- Wrap-around: after a release by requester 7 with req=8'h81.
  -> Next grant goes to 0 (sel=0, gnt=8'h01), not back to 7.
- Full contention: req=8'hFF held, MAX_BURST=1.
  -> sel sequence 0,1,2,3,4,5,6,7,0; each grant yields 1 q_valid pulse; q equals data_in[i] sampled that beat.
- Enable control: en=0 with req=8'h10.
  -> No grant. Raise en -> grant to 4 after 1 edge. Drop en mid-burst -> gnt=0 at the next edge with no further q_valid, then GAP then IDLE.
- Async reset mid-burst: assert rst_n low between clock edges during a grant to 3.
  -> gnt, sel, q, q_valid and busy all go to 0 immediately, without waiting for a clock edge.
  -> After release with req=8'h09: the grant goes to 0 (ptr was reset).
